// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID register and redirect/flush control.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BUBBLE | IF/ID holds a nop (after reset or a taken redirect)
// RUN    | IF/ID holds a real fetched instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misaligned
);

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] branch_dest;
    logic        take_jr;
    logic        take_j;
    logic        take_br;
    logic        redirect;

    // Redirects only count when IF/ID holds a real instruction.
    assign take_jr     = instr_valid & jump_reg;
    assign take_j      = instr_valid & jump;
    assign take_br     = instr_valid & branch_taken;
    assign redirect    = take_jr | take_j | take_br;
    assign pc_inc      = pc + 32'd4;
    assign branch_dest = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign imem_addr   = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUBBLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: stall holds, redirect inserts a bubble, otherwise run.
    always_comb begin
        state_next = state;
        if (!stall) begin
            state_next = redirect ? BUBBLE : RUN;
        end
    end

    // FSM output.
    always_comb begin
        instr_valid = (state == RUN);
    end

    // Next-PC selection in redirect priority order.
    always_comb begin
        pc_next = pc_inc;
        if (take_jr) begin
            pc_next = {reg_target[31:2], 2'b00};
        end else if (take_j) begin
            pc_next = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (take_br) begin
            pc_next = branch_dest;
        end
    end

    // PC and IF/ID register; a taken redirect flushes the wrong-path word.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= 32'h0;
            pc_plus4 <= 32'h0;
        end else if (!stall) begin
            pc <= pc_next;
            if (redirect) begin
                instr    <= 32'h0;
                pc_plus4 <= 32'h0;
            end else begin
                instr    <= imem_data;
                pc_plus4 <= pc_inc;
            end
        end
    end

    // Sticky flag for a jr target that was not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (!stall && take_jr && (reg_target[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free-run, stall, branch/jump/jr redirects, priority, wrap, reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misaligned;

    logic        reset2;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0;
    logic [25:0] zero26 = 26'h0;
    logic [31:0] zero32 = 32'h0;
    logic [31:0] imem_data2;
    logic [31:0] imem_addr2;
    logic [31:0] instr2;
    logic [31:0] pc_plus4_2;
    logic        instr_valid2;
    logic        misaligned2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory image: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_data  = mem_word(imem_addr);
    assign imem_data2 = mem_word(imem_addr2);

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .instr         (instr),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .misaligned    (misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .reset         (reset2),
        .stall         (zero1),
        .branch_taken  (zero1),
        .branch_offset (zero16),
        .jump          (zero1),
        .jump_target   (zero26),
        .jump_reg      (zero1),
        .reg_target    (zero32),
        .imem_data     (imem_data2),
        .imem_addr     (imem_addr2),
        .instr         (instr2),
        .pc_plus4      (pc_plus4_2),
        .instr_valid   (instr_valid2),
        .misaligned    (misaligned2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic v);
        check({tag, ".addr"},  imem_addr, a);
        check({tag, ".instr"}, instr, i);
        check({tag, ".pc4"},   pc_plus4, p);
        check({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_offset = 16'h0;
        jump = 1'b0; jump_target = 26'h0;
        jump_reg = 1'b0; reg_target = 32'h0;

        // reset state
        step();
        expect_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst.mis", {31'h0, misaligned}, 32'h0);
        check("wrap.rst_addr", imem_addr2, 32'hFFFF_FFFC);
        check("wrap.rst_valid", {31'h0, instr_valid2}, 32'h0);

        // free run
        reset = 1'b0; reset2 = 1'b0;
        step();
        expect_if("run1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
        check("wrap.addr", imem_addr2, 32'h0);
        check("wrap.instr", instr2, 32'h4FFF_FFFF);
        check("wrap.pc4", pc_plus4_2, 32'h0);
        step();
        expect_if("run2", 32'h8, 32'h1000_0001, 32'h8, 1'b1);

        // stall at pc = 8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_if("stall", 32'h8, 32'h1000_0001, 32'h8, 1'b1);
        end
        stall = 1'b0;
        step();
        expect_if("resume", 32'hC, 32'h1000_0002, 32'hC, 1'b1);
        step();
        expect_if("run4", 32'h10, 32'h1000_0003, 32'h10, 1'b1);

        // backward branch, then a redirect seen with instr_valid = 0 is ignored
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step();
        expect_if("br_back", 32'h8, 32'h0, 32'h0, 1'b0);
        step();
        expect_if("br_ignored", 32'hC, 32'h1000_0002, 32'hC, 1'b1);
        branch_taken = 1'b0;
        step();
        expect_if("run5", 32'h10, 32'h1000_0003, 32'h10, 1'b1);

        // forward branch
        branch_taken = 1'b1; branch_offset = 16'h0003;
        step();
        expect_if("br_fwd", 32'h1C, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_if("br_fwd_next", 32'h20, 32'h1000_0007, 32'h20, 1'b1);

        // jr into the 0x4xxx_xxxx region, then pseudo-direct jump
        jump_reg = 1'b1; reg_target = 32'h4000_000C;
        step();
        expect_if("jr_hi", 32'h4000_000C, 32'h0, 32'h0, 1'b0);
        jump_reg = 1'b0;
        step();
        expect_if("jr_hi_next", 32'h4000_0010, 32'h2000_0003, 32'h4000_0010, 1'b1);
        jump = 1'b1; jump_target = 26'h000_0100;
        step();
        expect_if("jmp", 32'h4000_0400, 32'h0, 32'h0, 1'b0);
        check("jmp.mis", {31'h0, misaligned}, 32'h0);
        jump = 1'b0;
        step();
        expect_if("jmp_next", 32'h4000_0404, 32'h2000_0100, 32'h4000_0404, 1'b1);

        // misaligned jr
        jump_reg = 1'b1; reg_target = 32'h0000_0022;
        step();
        expect_if("jr_mis", 32'h20, 32'h0, 32'h0, 1'b0);
        check("jr_mis.flag", {31'h0, misaligned}, 32'h1);
        jump_reg = 1'b0;
        step();
        expect_if("jr_mis_next", 32'h24, 32'h1000_0008, 32'h24, 1'b1);
        check("mis.sticky", {31'h0, misaligned}, 32'h1);

        // all three redirects together: jr wins
        jump_reg = 1'b1; reg_target = 32'h100;
        jump = 1'b1; jump_target = 26'h200;
        branch_taken = 1'b1; branch_offset = 16'h0005;
        step();
        expect_if("prio", 32'h100, 32'h0, 32'h0, 1'b0);
        clear_redirects();
        step();
        expect_if("prio_next", 32'h104, 32'h1000_0040, 32'h104, 1'b1);

        // redirect during stall is held off until stall drops
        stall = 1'b1; jump = 1'b1; jump_target = 26'h50;
        step();
        expect_if("stall_jmp", 32'h104, 32'h1000_0040, 32'h104, 1'b1);
        stall = 1'b0;
        step();
        expect_if("stall_jmp_rel", 32'h140, 32'h0, 32'h0, 1'b0);

        // reset mid-flush and mid-stall with a redirect pending
        stall = 1'b1; reset = 1'b1;
        step();
        expect_if("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst_mid.mis", {31'h0, misaligned}, 32'h0);
        reset = 1'b0; stall = 1'b0; clear_redirects();
        step();
        expect_if("post_rst", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
